mem_access_unit: RTL and testbench

Memory-side counterpart of the instruction decoder's one-hot memory controls. It consumes the store pick (sw/sh/sb/swl/swr), the load pick (lb/lbu/lh/lhu/lwl/lwr/lw), the effective address and register operands. It drives a word-aligned data-memory request/response handshake and returns the write-back value, already byte-extracted or merged, to the MEM/WB stage. The pipeline stalls on req_ready/resp_valid.

---
 rtl/mem_access_unit_pkg.sv | 51 +++++
 rtl/mem_lane_align.sv | 92 +++++++++
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: pick bit positions, FSM states, lane masks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_access_unit_pkg;

  // store_pick bit positions
  localparam int ST_SW  = 0;
  localparam int ST_SH  = 1;
  localparam int ST_SB  = 2;
  localparam int ST_SWL = 3;
  localparam int ST_SWR = 4;
  localparam int STORE_W = 5;

  // load_pick bit positions
  localparam int LD_LB  = 0;
  localparam int LD_LBU = 1;
  localparam int LD_LH  = 2;
  localparam int LD_LHU = 3;
  localparam int LD_LWL = 4;
  localparam int LD_LWR = 5;
  localparam int LD_LW  = 6;
  localparam int LOAD_W = 7;

  // byte-lane write masks
  localparam logic [3:0] LANE_NONE    = 4'b0000;
  localparam logic [3:0] LANE_ALL     = 4'b1111;
  localparam logic [3:0] LANE_LO_HALF = 4'b0011;
  localparam logic [3:0] LANE_HI_HALF = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // everything about an accepted op that the later states still need
  typedef struct packed {
    logic [STORE_W-1:0] store_pick;
    logic [LOAD_W-1:0]  load_pick;
    logic [1:0]         ofs;
    logic [31:0]        store_data;
    logic [31:0]        rt_old;
  } op_t;

  // true when zero or one bit is set
  function automatic logic at_most_one(input logic [7:0] v);
    return (v & (v - 8'd1)) == 8'd0;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/data from pick+ofs, load extraction/merge from the read word.
// Latency: purely combinational.
// Backpressure: none; the caller decides when inputs are valid.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [STORE_W-1:0] store_pick,
  input  logic [LOAD_W-1:0]  load_pick,
  input  logic [1:0]         ofs,
  input  logic [31:0]        store_data,
  input  logic [31:0]        rt_old,
  input  logic [31:0]        mem_rdata,
  output logic [3:0]         wen,
  output logic [31:0]        wdata,
  output logic [31:0]        load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // place store data on its lanes and raise the matching enables
  always_comb begin
    wen   = LANE_NONE;
    wdata = 32'h0;
    if (store_pick[ST_SW]) begin
      wen   = LANE_ALL;
      wdata = store_data;
    end else if (store_pick[ST_SH]) begin
      wen   = ofs[1] ? LANE_HI_HALF : LANE_LO_HALF;
      wdata = {store_data[15:0], store_data[15:0]};
    end else if (store_pick[ST_SB]) begin
      wen   = 4'b0001 << ofs;
      wdata = {4{store_data[7:0]}};
    end else if (store_pick[ST_SWL]) begin
      case (ofs)
        2'd0: begin wen = 4'b0001; wdata = store_data >> 24; end
        2'd1: begin wen = 4'b0011; wdata = store_data >> 16; end
        2'd2: begin wen = 4'b0111; wdata = store_data >> 8;  end
        default: begin wen = 4'b1111; wdata = store_data;    end
      endcase
    end else if (store_pick[ST_SWR]) begin
      case (ofs)
        2'd0: begin wen = 4'b1111; wdata = store_data;       end
        2'd1: begin wen = 4'b1110; wdata = store_data << 8;  end
        2'd2: begin wen = 4'b1100; wdata = store_data << 16; end
        default: begin wen = 4'b1000; wdata = store_data << 24; end
      endcase
    end
  end

  // pick the addressed byte and half out of the read word
  always_comb begin
    case (ofs)
      2'd0: sel_byte = mem_rdata[7:0];
      2'd1: sel_byte = mem_rdata[15:8];
      2'd2: sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = ofs[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // extend or merge into the write-back value
  always_comb begin
    load_data = 32'h0;
    if (load_pick[LD_LB]) begin
      load_data = {{24{sel_byte[7]}}, sel_byte};
    end else if (load_pick[LD_LBU]) begin
      load_data = {24'h0, sel_byte};
    end else if (load_pick[LD_LH]) begin
      load_data = {{16{sel_half[15]}}, sel_half};
    end else if (load_pick[LD_LHU]) begin
      load_data = {16'h0, sel_half};
    end else if (load_pick[LD_LW]) begin
      load_data = mem_rdata;
    end else if (load_pick[LD_LWL]) begin
      case (ofs)
        2'd0: load_data = {mem_rdata[7:0],  rt_old[23:0]};
        2'd1: load_data = {mem_rdata[15:0], rt_old[15:0]};
        2'd2: load_data = {mem_rdata[23:0], rt_old[7:0]};
        default: load_data = mem_rdata;
      endcase
    end else if (load_pick[LD_LWR]) begin
      case (ofs)
        2'd0: load_data = mem_rdata;
        2'd1: load_data = {rt_old[31:24], mem_rdata[31:8]};
        2'd2: load_data = {rt_old[31:16], mem_rdata[31:16]};
        default: load_data = {rt_old[31:8], mem_rdata[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage unit: one op at a time, word-aligned memory handshake, returns byte-steered write-back data.
// Latency: store resp 2 cycles after accept (zero-wait memory); load resp 1 cycle after mem_rdata_valid.
// Backpressure: req_ready low while busy; request held until mem_req_ready; result held until resp_ready.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [STORE_W-1:0] store_pick,
  input  logic [LOAD_W-1:0]  load_pick,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [31:0]        store_data,
  input  logic [31:0]        rt_old,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [3:0]         mem_wen,
  output logic [31:0]        mem_wdata,
  input  logic               mem_rdata_valid,
  input  logic [31:0]        mem_rdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_data,
  output logic               addr_err
);

  state_t state_q, state_d;
  op_t    op_q, op_d, live_op, align_op;

  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        mem_wen_d;
  logic [31:0]       mem_wdata_d;
  logic [31:0]       resp_data_d;
  logic              addr_err_d;

  logic [3:0]  align_wen;
  logic [31:0] align_wdata;
  logic [31:0] align_load;
  logic        pick_err, misalign, no_op;

  assign live_op = {store_pick, load_pick, addr[1:0], store_data, rt_old};

  // In IDLE the store lanes are built from the live inputs so they can be registered at accept;
  // afterwards the latched op drives the load extraction.
  assign align_op = (state_q == S_IDLE) ? live_op : op_q;

  mem_lane_align u_align (
    .store_pick (align_op.store_pick),
    .load_pick  (align_op.load_pick),
    .ofs        (align_op.ofs),
    .store_data (align_op.store_data),
    .rt_old     (align_op.rt_old),
    .mem_rdata  (mem_rdata),
    .wen        (align_wen),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  // classify the incoming op: illegal pick combination, misaligned, or nothing to do
  always_comb begin
    pick_err = !at_most_one({3'b000, store_pick}) || !at_most_one({1'b0, load_pick}) ||
               ((|store_pick) && (|load_pick));
    misalign = CHECK_ALIGN &&
               (((store_pick[ST_SW] || load_pick[LD_LW]) && (addr[1:0] != 2'b00)) ||
                ((store_pick[ST_SH] || load_pick[LD_LH] || load_pick[LD_LHU]) && addr[0]));
    no_op    = (store_pick == '0) && (load_pick == '0);
  end

  // next-state and next-output decode; every register holds unless a state says otherwise
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mem_addr_d  = mem_addr;
    mem_wen_d   = mem_wen;
    mem_wdata_d = mem_wdata;
    resp_data_d = resp_data;
    addr_err_d  = addr_err;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d        = live_op;
          resp_data_d = 32'h0;
          addr_err_d  = 1'b0;
          if (pick_err || misalign) begin
            addr_err_d = 1'b1;
            state_d    = S_RESP;
          end else if (no_op) begin
            state_d = S_RESP;
          end else begin
            mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            mem_wen_d   = align_wen;
            mem_wdata_d = align_wdata;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = (|op_q.store_pick) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rdata_valid) begin
          resp_data_d = align_load;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_data_d = 32'h0;
          addr_err_d  = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register plus the state-decoded handshake outputs, registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      resp_valid    <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready     <= (state_d == S_IDLE);
      mem_req_valid <= (state_d == S_REQ);
      resp_valid    <= (state_d == S_RESP);
    end
  end

  // latched op and datapath outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      mem_addr  <= '0;
      mem_wen   <= LANE_NONE;
      mem_wdata <= 32'h0;
      resp_data <= 32'h0;
      addr_err  <= 1'b0;
    end else begin
      op_q      <= op_d;
      mem_addr  <= mem_addr_d;
      mem_wen   <= mem_wen_d;
      mem_wdata <= mem_wdata_d;
      resp_data <= resp_data_d;
      addr_err  <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table through a zero-wait memory plus multi-cycle corner sequences.
// Latency: n/a.
// Backpressure: exercised by the hand-written sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  store_pick;
  logic [6:0]  load_pick;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] rt_old;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        addr_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .store_pick      (store_pick),
    .load_pick       (load_pick),
    .addr            (addr),
    .store_data      (store_data),
    .rt_old          (rt_old),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_addr        (mem_addr),
    .mem_wen         (mem_wen),
    .mem_wdata       (mem_wdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_data       (resp_data),
    .addr_err        (addr_err)
  );

  typedef struct packed {
    logic [4:0]  sp;
    logic [6:0]  lp;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rt;
    logic [31:0] m;
    logic [3:0]  exp_wen;
    logic [31:0] exp_wdata;
    logic [31:0] exp_resp;
    logic        exp_err;
    logic        memop;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    req_valid       = 1'b0;
    store_pick      = '0;
    load_pick       = '0;
    addr            = '0;
    store_data      = '0;
    rt_old          = '0;
    mem_req_ready   = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    resp_ready      = 1'b0;
  endtask

  // present one op at the current negedge; returns after the accepting posedge
  task automatic issue(input logic [4:0] sp, input logic [6:0] lp, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] rt);
    req_valid  = 1'b1;
    store_pick = sp;
    load_pick  = lp;
    addr       = a;
    store_data = b;
    rt_old     = rt;
    @(negedge clk);
    req_valid  = 1'b0;
    store_pick = '0;
    load_pick  = '0;
  endtask

  // full transaction with a zero-wait memory and an always-ready consumer
  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    check($sformatf("v%0d_req_ready", idx), {31'h0, req_ready}, 32'h1);
    issue(v.sp, v.lp, v.a, v.b, v.rt);
    if (v.memop) begin
      check($sformatf("v%0d_mem_req_valid", idx), {31'h0, mem_req_valid}, 32'h1);
      check($sformatf("v%0d_mem_addr", idx), mem_addr, {v.a[31:2], 2'b00});
      check($sformatf("v%0d_mem_wen", idx), {28'h0, mem_wen}, {28'h0, v.exp_wen});
      if (v.sp != 5'd0) check($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_wdata);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      if (v.lp != 7'd0) begin
        check($sformatf("v%0d_wait_no_resp", idx), {31'h0, resp_valid}, 32'h0);
        mem_rdata_valid = 1'b1;
        mem_rdata       = v.m;
        @(negedge clk);
        mem_rdata_valid = 1'b0;
      end
    end else begin
      check($sformatf("v%0d_no_mem_req", idx), {31'h0, mem_req_valid}, 32'h0);
    end
    check($sformatf("v%0d_resp_valid", idx), {31'h0, resp_valid}, 32'h1);
    check($sformatf("v%0d_resp_data", idx), resp_data, v.exp_resp);
    check($sformatf("v%0d_addr_err", idx), {31'h0, addr_err}, {31'h0, v.exp_err});
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    // store picks: sw=1 sh=2 sb=4 swl=8 swr=16; load picks: lb=1 lbu=2 lh=4 lhu=8 lwl=16 lwr=32 lw=64
    vecs[0]  = '{5'd1,  7'd0,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1};
    vecs[1]  = '{5'd2,  7'd0,  32'h0000_0102, 32'h0000_BEEF, 32'h0, 32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b1};
    vecs[2]  = '{5'd4,  7'd0,  32'h0000_1003, 32'h0000_00A5, 32'h0, 32'h0, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b1};
    vecs[3]  = '{5'd8,  7'd0,  32'h0000_0201, 32'h1234_5678, 32'h0, 32'h0, 4'b0011, 32'h0000_1234, 32'h0, 1'b0, 1'b1};
    vecs[4]  = '{5'd16, 7'd0,  32'h0000_3002, 32'h1234_5678, 32'h0, 32'h0, 4'b1100, 32'h5678_0000, 32'h0, 1'b0, 1'b1};
    vecs[5]  = '{5'd0,  7'd1,  32'h0000_2002, 32'h0, 32'h0, 32'h11F0_2233, 4'b0000, 32'h0, 32'hFFFF_FFF0, 1'b0, 1'b1};
    vecs[6]  = '{5'd0,  7'd2,  32'h0000_2002, 32'h0, 32'h0, 32'h11F0_2233, 4'b0000, 32'h0, 32'h0000_00F0, 1'b0, 1'b1};
    vecs[7]  = '{5'd0,  7'd4,  32'h0000_2002, 32'h0, 32'h0, 32'h8001_7FFF, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b0, 1'b1};
    vecs[8]  = '{5'd0,  7'd8,  32'h0000_2000, 32'h0, 32'h0, 32'h8001_7FFF, 4'b0000, 32'h0, 32'h0000_7FFF, 1'b0, 1'b1};
    vecs[9]  = '{5'd0,  7'd16, 32'h0000_0001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 4'b0000, 32'h0, 32'hCCDD_3344, 1'b0, 1'b1};
    vecs[10] = '{5'd0,  7'd32, 32'h0000_0001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 4'b0000, 32'h0, 32'h11AA_BBCC, 1'b0, 1'b1};
    vecs[11] = '{5'd0,  7'd64, 32'h0000_4000, 32'h0, 32'h0, 32'hCAFE_F00D, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1};
    vecs[12] = '{5'd0,  7'd64, 32'h0000_4001, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[13] = '{5'd2,  7'd0,  32'h0000_0001, 32'h1234_5678, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[14] = '{5'd0,  7'd0,  32'h0000_0040, 32'h1234_5678, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[15] = '{5'd5,  7'd0,  32'h0000_0040, 32'h1234_5678, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[16] = '{5'd1,  7'd64, 32'h0000_0040, 32'h1234_5678, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[17] = '{5'd0,  7'd16, 32'h0000_0003, 32'h0, 32'h1122_3344, 32'h0102_0304, 4'b0000, 32'h0, 32'h0102_0304, 1'b0, 1'b1};
    vecs[18] = '{5'd0,  7'd32, 32'h0000_0003, 32'h0, 32'h1122_3344, 32'h0102_0304, 4'b0000, 32'h0, 32'h1122_3301, 1'b0, 1'b1};

    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready",     {31'h0, req_ready},     32'h1);
    check("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check("rst_resp_valid",    {31'h0, resp_valid},    32'h0);
    check("rst_addr_err",      {31'h0, addr_err},      32'h0);
    check("rst_mem_wen",       {28'h0, mem_wen},       32'h0);
    check("rst_resp_data",     resp_data,              32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // stray read data while idle must be ignored
    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    check("idle_rdata_no_resp", {31'h0, resp_valid}, 32'h0);
    check("idle_rdata_ready",   {31'h0, req_ready},  32'h1);

    // store latency: accept, REQ, then RESP two cycles after accept
    issue(5'd4, 7'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0);
    mem_req_ready = 1'b1;
    check("sb_lat_c1_no_resp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("sb_lat_c2_resp", {31'h0, resp_valid}, 32'h1);
    check("sb_lat_c2_data", resp_data, 32'h0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // lb with three wait cycles before the read data
    issue(5'd0, 7'd1, 32'h0000_2002, 32'h0, 32'h0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("lb_wait%0d_no_resp", w), {31'h0, resp_valid}, 32'h0);
      check($sformatf("lb_wait%0d_busy", w), {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'h11F0_2233;
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    check("lb_wait_resp_valid", {31'h0, resp_valid}, 32'h1);
    check("lb_wait_resp_data",  resp_data, 32'hFFFF_FFF0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // swr with the memory stalling four cycles: request must stay stable
    issue(5'd16, 7'd0, 32'h0000_3002, 32'h1234_5678, 32'h0);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("swr_stall%0d_valid", w), {31'h0, mem_req_valid}, 32'h1);
      check($sformatf("swr_stall%0d_addr", w),  mem_addr, 32'h0000_3000);
      check($sformatf("swr_stall%0d_wen", w),   {28'h0, mem_wen}, 32'hC);
      check($sformatf("swr_stall%0d_wdata", w), mem_wdata, 32'h5678_0000);
      check($sformatf("swr_stall%0d_busy", w),  {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("swr_stall_drop_req", {31'h0, mem_req_valid}, 32'h0);
    check("swr_stall_resp",     {31'h0, resp_valid},    32'h1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // misaligned lw with the consumer stalling two cycles
    issue(5'd0, 7'd64, 32'h0000_4001, 32'h0, 32'h0);
    for (int w = 0; w < 2; w++) begin
      check($sformatf("lw_err_hold%0d_valid", w), {31'h0, resp_valid}, 32'h1);
      check($sformatf("lw_err_hold%0d_err", w),   {31'h0, addr_err},   32'h1);
      check($sformatf("lw_err_hold%0d_noreq", w), {31'h0, mem_req_valid}, 32'h0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("lw_err_idle_ready", {31'h0, req_ready},  32'h1);
    check("lw_err_idle_resp",  {31'h0, resp_valid}, 32'h0);
    check("lw_err_idle_err",   {31'h0, addr_err},   32'h0);

    // reset while waiting on a load, then late read data
    issue(5'd0, 7'd4, 32'h0000_2002, 32'h0, 32'h0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready",   {31'h0, req_ready},     32'h1);
    check("mid_rst_noreq",   {31'h0, mem_req_valid}, 32'h0);
    check("mid_rst_no_resp", {31'h0, resp_valid},    32'h0);
    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'h8001_7FFF;
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    check("late_rdata_no_resp", {31'h0, resp_valid}, 32'h0);
    check("late_rdata_ready",   {31'h0, req_ready},  32'h1);
    run_vec(11);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
